// File: rtl/add_pipe_pkg.sv
// Shared types and default sizes for the add_pipe adder stage.
package add_pipe_pkg;

  localparam int ADD_PIPE_DEFAULT_WIDTH       = 4;
  localparam int ADD_PIPE_DEFAULT_DEPTH       = 4;
  localparam int ADD_PIPE_DEFAULT_COUNT_WIDTH = 16;

  typedef struct packed {
    logic                              carry;
    logic [ADD_PIPE_DEFAULT_WIDTH-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle between the add_in initiator and the adder stage.
interface add_pipe_if
  import add_pipe_pkg::*;
#(
  parameter int add_width   = ADD_PIPE_DEFAULT_WIDTH,
  parameter int COUNT_WIDTH = ADD_PIPE_DEFAULT_COUNT_WIDTH
);
  logic                   in_valid;
  logic                   in_ready;
  logic [add_width-1:0]   a;
  logic [add_width-1:0]   b;
  logic                   out_valid;
  logic                   out_ready;
  logic [add_width-1:0]   sum;
  logic                   carry;
  logic [COUNT_WIDTH-1:0] txn_count;
  logic [COUNT_WIDTH-1:0] carry_count;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry, txn_count, carry_count
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry, txn_count, carry_count
  );
endinterface

// File: rtl/add_pipe_fifo.sv
// Generic synchronous FIFO, push-to-head latency 1 cycle; caller guarantees no push when full
// and no pop when empty. Simultaneous push/pop keeps count and advances both pointers.
module add_pipe_fifo
  import add_pipe_pkg::*;
#(
  parameter type data_t = add_result_t,
  parameter int  DEPTH  = ADD_PIPE_DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  data_t                  push_dat,
  input  logic                   pop,
  output data_t                  head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  data_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Pointers are exactly log2(DEPTH) wide, so they wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/add_pipe_unit.sv
// Operand register + adder feeding an output FIFO; accept-to-out_valid latency 2 cycles.
// in_ready is a credit check on FIFO + s1 occupancy, so the FIFO never overflows under backpressure.
module add_pipe_unit
  import add_pipe_pkg::*;
#(
  parameter int add_width   = ADD_PIPE_DEFAULT_WIDTH,
  parameter int FIFO_DEPTH  = ADD_PIPE_DEFAULT_DEPTH,
  parameter int COUNT_WIDTH = ADD_PIPE_DEFAULT_COUNT_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  add_pipe_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 2;
  localparam logic [OW-1:0]          DEPTH_L = OW'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic                 carry;
    logic [add_width-1:0] sum;
  } result_t;

  logic                 s1_valid;
  logic [add_width-1:0] a_s1;
  logic [add_width-1:0] b_s1;
  logic                 accept;
  logic                 pop;
  result_t              s2_res;
  result_t              head;
  logic [PW:0]          fifo_count;
  logic [OW-1:0]        occupancy;

  // A same-cycle pop is ignored here on purpose: simpler timing, one bubble at full.
  assign occupancy    = OW'(fifo_count) + OW'(s1_valid);
  assign bus.in_ready = occupancy < DEPTH_L;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s1_valid <= 1'b0;
    else      s1_valid <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_s1 <= bus.a;
      b_s1 <= bus.b;
    end
  end

  assign s2_res = {1'b0, a_s1} + {1'b0, b_s1};

  add_pipe_fifo #(
    .data_t (result_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (s1_valid),
    .push_dat (s2_res),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  // Unreset FIFO storage is masked so nothing undefined leaks while empty.
  assign bus.out_valid = (fifo_count != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.sum       = bus.out_valid ? head.sum : '0;
  assign bus.carry     = bus.out_valid ? head.carry : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.txn_count   <= '0;
      bus.carry_count <= '0;
    end else if (pop) begin
      if (bus.txn_count != CNT_MAX)
        bus.txn_count <= bus.txn_count + COUNT_WIDTH'(1);
      if (head.carry && bus.carry_count != CNT_MAX)
        bus.carry_count <= bus.carry_count + COUNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_add_pipe_unit.sv
// Randomised bench for add_pipe_unit against a queue-based transaction model.
module tb_add_pipe_unit;
  localparam int W = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  add_pipe_if #(.add_width(W), .COUNT_WIDTH(16)) bus ();
  add_pipe_if #(.add_width(W), .COUNT_WIDTH(3))  sat_bus ();

  add_pipe_unit #(.add_width(W), .FIFO_DEPTH(D), .COUNT_WIDTH(16)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  add_pipe_unit #(.add_width(W), .FIFO_DEPTH(D), .COUNT_WIDTH(3)) dut_sat (
    .clk (clk), .rst (rst), .bus (sat_bus)
  );

  typedef struct {
    int s;
    int c;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   errs    = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   m_txn   = 0;
  int   m_carry = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input int a, input int b, input bit r);
    bus.in_valid  = v;
    bus.a         = a[W-1:0];
    bus.b         = b[W-1:0];
    bus.out_ready = r;
  endtask

  // One clock of the reference: every accepted pair is visible two cycles later, in order,
  // and the unit admits a new pair only while fewer than D pairs are in flight.
  task automatic cycle(output bit acc);
    bit rdy;
    bit ov;
    int es;
    int ec;
    int s;
    rdy = q.size() < D;
    ov  = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
    es  = 0;
    ec  = 0;
    if (ov) begin
      es = q[0].s;
      ec = q[0].c;
    end
    chk("in_ready",    bus.in_ready,    rdy);
    chk("out_valid",   bus.out_valid,   ov);
    chk("sum",         bus.sum,         es);
    chk("carry",       bus.carry,       ec);
    chk("txn_count",   bus.txn_count,   m_txn);
    chk("carry_count", bus.carry_count, m_carry);
    acc = bus.in_valid && rdy;
    if (ov && bus.out_ready) begin
      if (m_txn < 65535) m_txn++;
      if (ec == 1 && m_carry < 65535) m_carry++;
      void'(q.pop_front());
    end
    if (acc) begin
      s = int'(bus.a) + int'(bus.b);
      q.push_back('{s % 16, s / 16, cyc});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bit acc;
    bit done;
    int n;
    int ra;
    int rb;
    int dut_acc;
    int exp_cnt;

    drive(0, 0, 0, 1);
    sat_bus.in_valid  = 1'b0;
    sat_bus.a         = '0;
    sat_bus.b         = '0;
    sat_bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",   bus.out_valid,   0);
    chk("rst_sum",         bus.sum,         0);
    chk("rst_carry",       bus.carry,       0);
    chk("rst_txn",         bus.txn_count,   0);
    chk("rst_carry_count", bus.carry_count, 0);
    rst = 1'b1;

    // Basic add and carry cases
    drive(1, 3, 5, 1);
    cycle(acc);
    drive(0, 0, 0, 1);
    repeat (3) cycle(acc);
    chk("basic_txn", bus.txn_count, 1);
    drive(1, 15, 1, 1);
    cycle(acc);
    drive(1, 15, 15, 1);
    cycle(acc);
    drive(0, 0, 0, 1);
    repeat (4) cycle(acc);
    chk("carry_cnt", bus.carry_count, 2);

    // Backpressure: only D pairs fit with the consumer stalled
    n = 1;
    dut_acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, n, n, 0);
      if (bus.in_ready) dut_acc++;
      cycle(acc);
      if (acc) n++;
    end
    chk("bp_accepts",  dut_acc,      4);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_head",     bus.sum,      2);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      drive(1, 5, 5, 1);
      cycle(acc);
      done = acc;
    end
    chk("bp_reaccept", done, 1);
    drive(0, 0, 0, 1);
    repeat (8) cycle(acc);
    chk("bp_txn", bus.txn_count, 8);

    // Fill the FIFO, then stream 20 random pairs through it at full occupancy
    ra = $urandom_range(0, 15);
    rb = $urandom_range(0, 15);
    for (int i = 0; i < 6; i++) begin
      drive(1, ra, rb, 0);
      cycle(acc);
      if (acc) begin
        ra = $urandom_range(0, 15);
        rb = $urandom_range(0, 15);
      end
    end
    n = 0;
    for (int i = 0; i < 200 && n < 20; i++) begin
      drive(1, ra, rb, 1);
      cycle(acc);
      if (acc) begin
        n++;
        ra = $urandom_range(0, 15);
        rb = $urandom_range(0, 15);
      end
    end
    chk("stream_fed", n, 20);
    drive(0, 0, 0, 1);
    repeat (8) cycle(acc);
    chk("stream_drained", bus.out_valid, 0);

    // Random valid/ready mix
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1));
      cycle(acc);
    end
    drive(0, 0, 0, 1);
    repeat (8) cycle(acc);

    // Reset with three results queued
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom_range(0, 15), $urandom_range(0, 15), 0);
      cycle(acc);
    end
    drive(0, 0, 0, 0);
    cycle(acc);
    chk("pre_rst_queued", bus.out_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid",   bus.out_valid,   0);
    chk("mid_rst_sum",         bus.sum,         0);
    chk("mid_rst_txn",         bus.txn_count,   0);
    chk("mid_rst_carry_count", bus.carry_count, 0);
    q.delete();
    m_txn   = 0;
    m_carry = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
    drive(1, 6, 7, 1);
    cycle(acc);
    drive(0, 0, 0, 1);
    repeat (3) cycle(acc);
    chk("post_rst_txn", bus.txn_count, 1);

    // Saturation on the 3-bit counter instance: ten 8+8 results
    for (int k = 0; k < 15; k++) begin
      sat_bus.in_valid = (k < 10);
      sat_bus.a        = 4'h8;
      sat_bus.b        = 4'h8;
      exp_cnt = (k < 2) ? 0 : k - 2;
      if (exp_cnt > 7) exp_cnt = 7;
      chk("sat_txn",   sat_bus.txn_count,   exp_cnt);
      chk("sat_carry", sat_bus.carry_count, exp_cnt);
      @(posedge clk);
      #1;
    end
    sat_bus.in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/add_pipe_unit.md
Name: add_pipe_unit

Overview:
- Adder datapath stage directly downstream of the add_in bus; consumes operands a/b and produces sum/carry.
- Valid/ready handshake on both sides. One operand register stage, then a small output FIFO that absorbs backpressure.
- Saturating transaction and carry-out counters for scoreboard/coverage visibility.
- Sits between the add_in agent (initiator) and the result-side agent/monitor.

Parameters:
- add_width, 4, operand and sum width in bits.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
- COUNT_WIDTH, 16, width of the txn_count and carry_count counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  unit can accept operands this cycle.
- a  input  add_width  operand A.
- b  input  add_width  operand B.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer accepts the head result.
- sum  output  add_width  head result, (a+b) mod 2^add_width.
- carry  output  1  head result carry-out.
- txn_count  output  COUNT_WIDTH  results popped, saturating.
- carry_count  output  COUNT_WIDTH  popped results with carry=1, saturating.

Behaviour:
- Reset (rst low, async assert; deassertion synchronised by the environment):
  - s1_valid=0; FIFO pointers and count=0.
  - out_valid=0, sum=0, carry=0, txn_count=0, carry_count=0.
  - in_ready=1 in the first cycle after release.
- Input handshake:
  - Accept when in_valid && in_ready at a rising edge.
  - a/b are captured into the s1 register and s1_valid is set.
  - a/b may change freely when not accepted.
- Stage 2:
  - {carry,sum} = a_s1 + b_s1, computed at add_width+1 bits with zero extension.
  - Written to the FIFO at the next edge whenever s1_valid=1. The FIFO never rejects this write; the credit rule below guarantees space.
  - s1_valid clears at that edge unless a new accept occurs in the same cycle.
- Credit rule:
  - in_ready = (fifo_count + s1_valid) < FIFO_DEPTH, combinational.
  - A same-cycle pop does not raise in_ready (deliberately conservative).
- Latency: accept in cycle 0 -> out_valid with that result in cycle 2 if the FIFO was empty. Throughput is 1 result/cycle with out_ready held high.
- Output:
  - out_valid = (fifo_count != 0); sum/carry are driven from the FIFO head.
  - Pop on out_valid && out_ready.
  - Head data and out_valid stay stable while out_valid && !out_ready.
- FIFO ordering and boundaries:
  - Strict in-order.
  - Simultaneous push and pop: count unchanged, both pointers advance. This is legal when full and when holding one entry.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters:
  - Both increment only on pop; carry_count increments only when the popped carry=1.
  - Both hold at 2^COUNT_WIDTH-1, with no wrap.
- Reset mid-operation: all in-flight s1 data and FIFO contents are discarded immediately, counters clear, and no partial result appears after release.
- X-safety: s1 data and FIFO data are not reset, but their contents are never visible while out_valid=0 (sum/carry are forced to 0 when empty).

Decomposition:
- add_pipe_pkg holds:
  - typedef add_result_t (packed struct {carry, sum[add_width-1:0]}), parameterised through a package-level default width constant.
  - ADD_PIPE_DEFAULT_DEPTH=4 and ADD_PIPE_DEFAULT_COUNT_WIDTH=16.
- Sub-module add_pipe_fifo:
  - Generic sync FIFO of add_result_t, depth FIFO_DEPTH.
  - Ports push/pop/count/head, with the same clk and active-low async rst.
- The top holds the s1 register, adder, credit logic and counters.

Test Plan:
- Basic add: a=4'h3, b=4'h5, out_ready=1 -> sum=4'h8, carry=0, out_valid in cycle 2; txn_count=1, carry_count=0.
- Carry: a=4'hF, b=4'h1 -> sum=4'h0, carry=1; a=4'hF, b=4'hF -> sum=4'hE, carry=1; carry_count=2.
- Backpressure: out_ready=0, in_valid=1 with pairs (1,1),(2,2),(3,3),(4,4),(5,5) -> exactly 4 accepted; in_ready=0 after the 4th accept. Head holds 4'h2 stably. Raising out_ready yields 2,4,6,8, then 5+5=4'hA after re-accept.
- Full with simultaneous push/pop: FIFO full, out_ready=1 every cycle, continuous in_valid -> in_ready pulses per the credit rule, no loss or duplication, output order equals input order over 20 random pairs.
- Reset mid-stream: 3 results queued, rst low for 1 cycle -> out_valid=0, counters=0 immediately; after release, next input (6,7) -> sum=4'hD, carry=0 as the first result.
- Saturation (COUNT_WIDTH=3): 10 pops with a=4'h8, b=4'h8 -> txn_count and carry_count both stick at 7.
